result_axil_slv: RTL and testbench
==================================

# result_axil_slv

AXI4-Lite responder that captures fabric result samples (XADC conversion results) into a small FIFO and exposes them to the PS through a four-register map. It is the slave end of the AXI4-Lite link driven by the PS/VIP master on `S00_AXI`. It handles the single-beat write and read handshakes, sticky status and a level-threshold interrupt.

## Interface
Parameters:
- `C_S_AXI_DATA_WIDTH`, 32: AXI data width; only 32 is supported.
- `C_S_AXI_ADDR_WIDTH`, 4: byte address width; the register index is `addr[3:2]`.
- `FIFO_DEPTH`, 8: result FIFO depth; must be a power of 2, range 2..256.
- `RESULT_WIDTH`, 16: result sample width, range 1..32.

Ports:
- `ACLK` in 1: the single clock.
- `ARESET` in 1: reset, synchronous, active-high.
- `S_AXI_AWADDR` in `C_S_AXI_ADDR_WIDTH`; `S_AXI_AWPROT` in 3 (ignored); `S_AXI_AWVALID` in 1; `S_AXI_AWREADY` out 1.
- `S_AXI_WDATA` in 32; `S_AXI_WSTRB` in 4; `S_AXI_WVALID` in 1; `S_AXI_WREADY` out 1.
- `S_AXI_BRESP` out 2; `S_AXI_BVALID` out 1; `S_AXI_BREADY` in 1.
- `S_AXI_ARADDR` in `C_S_AXI_ADDR_WIDTH`; `S_AXI_ARPROT` in 3 (ignored); `S_AXI_ARVALID` in 1; `S_AXI_ARREADY` out 1.
- `S_AXI_RDATA` out 32; `S_AXI_RRESP` out 2; `S_AXI_RVALID` out 1; `S_AXI_RREADY` in 1.
- `res_valid` in 1: a result sample is present this cycle.
- `res_data` in `RESULT_WIDTH`: the result sample.
- `enable` out 1: copy of `CTRL[0]`, gates the upstream sampler.
- `irq` out 1: level-threshold / overflow interrupt, registered.

## Operation
Register map:
- 0x0 `CTRL` (RW):
  - [0] enable.
  - [1] irq_en.
  - [2] flush; write-1 pulse, reads 0.
- 0x4 `THRESH` (RW): bits [8:0]; all other bits read 0.
- 0x8 `DATA` (RO): a read pops the FIFO head and returns it zero-extended.
  - Read while empty returns 0 and sets underflow.
- 0xC `STATUS` (RO except W1C bits):
  - [0] empty.
  - [1] full.
  - [2] overflow, sticky, W1C.
  - [3] underflow, sticky, W1C.
  - [24:16] level.

Write behaviour:
- `WSTRB` byte lanes are honoured for `CTRL`, `THRESH` and the W1C bits of `STATUS`.
- A write to `DATA` changes nothing and returns `BRESP`=SLVERR (2'b10).
- All other responses are OKAY.

Capture:
- Push when `res_valid` & enable & !full.
- `res_valid` & enable & full (and no pop in the same cycle) drops the sample and sets overflow.
- `res_valid` is ignored while enable=0.

Interrupt:
- `irq` (registered) = irq_en & ((THRESH≠0 & level≥THRESH) | overflow).

Boundary rules:
- Push and pop in the same cycle: level unchanged. When full, the push is accepted and no overflow is flagged.
- Empty with simultaneous push and pop: the pop reports underflow and returns 0; the push is stored, so level becomes 1.
- Flush: level←0 and pointers←0 in the next cycle.
  - A push in the flush cycle is dropped without setting overflow.
  - Sticky bits are not cleared by flush.
- Pointer wrap: modulo `FIFO_DEPTH`. Level uses log2(`FIFO_DEPTH`)+1 bits.

## Timing
- Reset state:
  - AXI outputs: `S_AXI_AWREADY`, `S_AXI_WREADY`, `S_AXI_BVALID`, `S_AXI_ARREADY`, `S_AXI_RVALID` = 0; `S_AXI_BRESP`, `S_AXI_RRESP` = 0; `S_AXI_RDATA` = 0.
  - `enable`, `irq` = 0.
  - All registers 0; FIFO empty; sticky bits 0.
- Reset mid-transaction abandons it: the pending `BVALID`/`RVALID` drops the cycle after `ARESET` is sampled.
- Write channel, states W_IDLE → W_RESP:
  - In W_IDLE, with `AWVALID` & `WVALID` both high, `AWREADY` and `WREADY` pulse together for exactly 1 cycle and the register updates on that edge.
  - `BVALID` rises the next cycle and holds, with `BRESP` stable, until `BREADY`; then return to W_IDLE.
  - No new AW/W is accepted while in W_RESP. AW without W (or W without AW) waits; no ready is asserted.
- Read channel, states R_IDLE → R_DATA:
  - In R_IDLE, `ARVALID` gives a 1-cycle `ARREADY` pulse. `RDATA` is latched and the pop is performed on that edge.
  - `RVALID` rises the next cycle and holds, with data stable, until `RREADY`.
  - Read latency: AR handshake to `RVALID` = 1 cycle.
- Write and read channels are independent and may complete in the same cycle.
- `STATUS`/level reflect FIFO updates 1 cycle after the push or pop edge; `irq` lags by one further cycle.

## Configuration
- `RESULT_SLV_SIGN_EXT_EN` defined: `DATA` reads sign-extend `res_data` from bit `RESULT_WIDTH-1` to 32 bits.
- Not defined: zero-extend.
- No other behaviour changes.

## Test plan
- Reset, then read 0x0/0x4/0x8/0xC → 0, 0, 0 with underflow set, then STATUS=0x0000_0009. Write 0x8 to STATUS → STATUS=0x0000_0001.
- Write CTRL=1, push 0x0001..0x0004, read DATA ×4 → 1, 2, 3, 4; STATUS level=0, empty=1; every `RVALID` exactly 1 cycle after `ARREADY`.
- Push 9 samples (depth 8) → level 8, full=1, overflow=1; DATA read returns the first sample. Push and pop in the same cycle while full → level stays 8, no new overflow.
- THRESH=3, CTRL=3, push 3 samples → `irq` high 2 cycles after the third push; one DATA read → `irq` low.
- Hold `BREADY`=0 for 5 cycles after a write → `BVALID` and `BRESP` stable, `AWREADY` stays 0. A write to 0x8 → `BRESP`=2'b10. Assert `ARESET` mid-wait → `BVALID`=0 next cycle.
- Push 0x8000 with `RESULT_SLV_SIGN_EXT_EN` → DATA reads 0xFFFF_8000; without the macro → 0x0000_8000.

Source files
------------

// File: rtl/result_axil_slv.sv
// result_axil_slv: AXI4-Lite slave that buffers fabric result samples
// (XADC conversions) in a FIFO and exposes them through four registers.
//
// Ports:
//   ACLK, ARESET        clock, synchronous active-high reset
//   S_AXI_*             AXI4-Lite slave (AW/W/B write, AR/R read)
//   res_valid/res_data  result sample input
//   enable              CTRL[0], gates the upstream sampler
//   irq                 level-threshold / overflow interrupt (registered)
//
// Register map: 0x0 CTRL {flush,irq_en,enable}, 0x4 THRESH[8:0],
//   0x8 DATA (read pops), 0xC STATUS {level[24:16],udf,ovf,full,empty}.
//
// Build option: RESULT_SLV_SIGN_EXT_EN makes DATA reads sign-extend the
//   sample from bit RESULT_WIDTH-1; otherwise DATA is zero-extended.

module result_axil_slv #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4,
   parameter int FIFO_DEPTH         = 8,
   parameter int RESULT_WIDTH       = 16
) (
   input  logic                          ACLK,
   input  logic                          ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
   input  logic [2:0]                    S_AXI_AWPROT,
   input  logic                          S_AXI_AWVALID,
   output logic                          S_AXI_AWREADY,
   input  logic [31:0]                   S_AXI_WDATA,
   input  logic [3:0]                    S_AXI_WSTRB,
   input  logic                          S_AXI_WVALID,
   output logic                          S_AXI_WREADY,
   output logic [1:0]                    S_AXI_BRESP,
   output logic                          S_AXI_BVALID,
   input  logic                          S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
   input  logic [2:0]                    S_AXI_ARPROT,
   input  logic                          S_AXI_ARVALID,
   output logic                          S_AXI_ARREADY,
   output logic [31:0]                   S_AXI_RDATA,
   output logic [1:0]                    S_AXI_RRESP,
   output logic                          S_AXI_RVALID,
   input  logic                          S_AXI_RREADY,
   input  logic                          res_valid,
   input  logic [RESULT_WIDTH-1:0]       res_data,
   output logic                          enable,
   output logic                          irq
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = PW + 1;

   typedef enum logic {W_IDLE, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   w_state_t w_state;
   r_state_t r_state;

   logic              ctrl_en, irq_en;
   logic [8:0]        thresh;
   logic              ovf, udf;
   logic [RESULT_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]     wptr, rptr;
   logic [LW-1:0]     level;
   logic [8:0]        lvl9;
   logic              empty, full;
   logic              wr_hs, rd_hs;
   logic [1:0]        widx, ridx;
   logic              flush, push_req, pop_req;
   logic              push_ok, pop_ok;
   logic              ovf_set, udf_set, ovf_clr, udf_clr;
   logic [31:0]       rd_mux;
   logic              unused_bits;

   function automatic logic [31:0] ext(input logic [RESULT_WIDTH-1:0] d);
`ifdef RESULT_SLV_SIGN_EXT_EN
      logic signed [RESULT_WIDTH-1:0] s;
      s = signed'(d);
      return 32'(s);
`else
      return 32'(d);
`endif
   endfunction

   assign wr_hs = S_AXI_AWREADY & S_AXI_AWVALID
                & S_AXI_WREADY & S_AXI_WVALID;
   assign rd_hs = S_AXI_ARREADY & S_AXI_ARVALID;
   assign widx  = S_AXI_AWADDR[3:2];
   assign ridx  = S_AXI_ARADDR[3:2];

   assign empty = (level == '0);
   assign full  = (level == LW'(FIFO_DEPTH));
   assign lvl9  = 9'(level);

   assign flush = wr_hs & (widx == 2'd0)
                & S_AXI_WSTRB[0] & S_AXI_WDATA[2];
   assign ovf_clr = wr_hs & (widx == 2'd3)
                  & S_AXI_WSTRB[0] & S_AXI_WDATA[2];
   assign udf_clr = wr_hs & (widx == 2'd3)
                  & S_AXI_WSTRB[0] & S_AXI_WDATA[3];

   assign push_req = res_valid & ctrl_en;
   assign pop_req  = rd_hs & (ridx == 2'd2);
   assign pop_ok   = pop_req & ~empty;
   // A pop on the same edge frees a slot, so a full FIFO still accepts.
   assign push_ok  = push_req & ~flush & (~full | pop_ok);
   assign ovf_set  = push_req & ~flush & full & ~pop_ok;
   assign udf_set  = pop_req & empty;

   assign enable = ctrl_en;
   assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                          S_AXI_WDATA[31:9], S_AXI_WSTRB[3:2],
                          S_AXI_AWADDR, S_AXI_ARADDR};

   always_comb begin
      rd_mux = '0;
      unique case (ridx)
         2'd0: rd_mux = {30'd0, irq_en, ctrl_en};
         2'd1: rd_mux = {23'd0, thresh};
         2'd2: rd_mux = empty ? 32'd0 : ext(mem[rptr]);
         2'd3: rd_mux = {7'd0, lvl9, 12'd0, udf, ovf, full, empty};
      endcase
   end

   // Write channel: ready pulses once both AW and W are presented.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         w_state       <= W_IDLE;
         S_AXI_AWREADY <= 1'b0;
         S_AXI_WREADY  <= 1'b0;
         S_AXI_BVALID  <= 1'b0;
         S_AXI_BRESP   <= 2'b00;
      end else begin
         unique case (w_state)
            W_IDLE: begin
               if (wr_hs) begin
                  S_AXI_AWREADY <= 1'b0;
                  S_AXI_WREADY  <= 1'b0;
                  S_AXI_BVALID  <= 1'b1;
                  S_AXI_BRESP   <= (widx == 2'd2) ? 2'b10 : 2'b00;
                  w_state       <= W_RESP;
               end else begin
                  S_AXI_AWREADY <= S_AXI_AWVALID & S_AXI_WVALID;
                  S_AXI_WREADY  <= S_AXI_AWVALID & S_AXI_WVALID;
               end
            end
            W_RESP: begin
               if (S_AXI_BREADY) begin
                  S_AXI_BVALID <= 1'b0;
                  w_state      <= W_IDLE;
               end
            end
         endcase
      end
   end

   // Read channel: data is captured on the AR handshake edge.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_state       <= R_IDLE;
         S_AXI_ARREADY <= 1'b0;
         S_AXI_RVALID  <= 1'b0;
         S_AXI_RDATA   <= '0;
         S_AXI_RRESP   <= 2'b00;
      end else begin
         S_AXI_RRESP <= 2'b00;
         unique case (r_state)
            R_IDLE: begin
               if (rd_hs) begin
                  S_AXI_ARREADY <= 1'b0;
                  S_AXI_RVALID  <= 1'b1;
                  S_AXI_RDATA   <= rd_mux;
                  r_state       <= R_DATA;
               end else begin
                  S_AXI_ARREADY <= S_AXI_ARVALID;
               end
            end
            R_DATA: begin
               if (S_AXI_RREADY) begin
                  S_AXI_RVALID <= 1'b0;
                  r_state      <= R_IDLE;
               end
            end
         endcase
      end
   end

   always_ff @(posedge ACLK) begin
      if (push_ok) mem[wptr] <= res_data;
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         ctrl_en <= 1'b0;
         irq_en  <= 1'b0;
         thresh  <= '0;
         ovf     <= 1'b0;
         udf     <= 1'b0;
         wptr    <= '0;
         rptr    <= '0;
         level   <= '0;
         irq     <= 1'b0;
      end else begin
         if (wr_hs && widx == 2'd0 && S_AXI_WSTRB[0]) begin
            ctrl_en <= S_AXI_WDATA[0];
            irq_en  <= S_AXI_WDATA[1];
         end
         if (wr_hs && widx == 2'd1) begin
            if (S_AXI_WSTRB[0]) thresh[7:0] <= S_AXI_WDATA[7:0];
            if (S_AXI_WSTRB[1]) thresh[8]   <= S_AXI_WDATA[8];
         end
         // A new event in the clearing cycle keeps the bit set.
         ovf <= ovf_set | (ovf & ~ovf_clr);
         udf <= udf_set | (udf & ~udf_clr);

         if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
         end else begin
            if (push_ok) wptr <= wptr + PW'(1);
            if (pop_ok)  rptr <= rptr + PW'(1);
            unique case ({push_ok, pop_ok})
               2'b10:   level <= level + LW'(1);
               2'b01:   level <= level - LW'(1);
               default: level <= level;
            endcase
         end

         irq <= irq_en & (((thresh != '0) && (lvl9 >= thresh)) | ovf);
      end
   end

endmodule

// File: tb/tb_result_axil_slv.sv
// tb_result_axil_slv: directed bench for result_axil_slv.
// Drives AXI4-Lite transfers and result samples, checks hand-computed values.

module tb_result_axil_slv;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  awaddr, araddr;
   logic [2:0]  awprot, arprot;
   logic        awvalid, awready, wvalid, wready;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;
   logic        bvalid, bready, arvalid, arready, rvalid, rready;
   logic        res_valid;
   logic [15:0] res_data;
   logic        enable, irq;

   int tests = 0;
   int fails = 0;
   localparam int LIM = 20;

   always #5 clk = ~clk;

   result_axil_slv dut (
      .ACLK          (clk),
      .ARESET        (rst),
      .S_AXI_AWADDR  (awaddr),
      .S_AXI_AWPROT  (awprot),
      .S_AXI_AWVALID (awvalid),
      .S_AXI_AWREADY (awready),
      .S_AXI_WDATA   (wdata),
      .S_AXI_WSTRB   (wstrb),
      .S_AXI_WVALID  (wvalid),
      .S_AXI_WREADY  (wready),
      .S_AXI_BRESP   (bresp),
      .S_AXI_BVALID  (bvalid),
      .S_AXI_BREADY  (bready),
      .S_AXI_ARADDR  (araddr),
      .S_AXI_ARPROT  (arprot),
      .S_AXI_ARVALID (arvalid),
      .S_AXI_ARREADY (arready),
      .S_AXI_RDATA   (rdata),
      .S_AXI_RRESP   (rresp),
      .S_AXI_RVALID  (rvalid),
      .S_AXI_RREADY  (rready),
      .res_valid     (res_valid),
      .res_data      (res_data),
      .enable        (enable),
      .irq           (irq)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // AW/W handshake only; leaves the B response pending.
   task automatic aw_w(input logic [3:0] a, input logic [31:0] d,
                       input logic [3:0] s);
      int n;
      awaddr = a; wdata = d; wstrb = s;
      awvalid = 1'b1; wvalid = 1'b1;
      n = 0;
      while (!awready && n < LIM) begin
         tick();
         n++;
      end
      check("aw_ready", 32'(awready), 1);
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      check("w_bvalid", 32'(bvalid), 1);
   endtask

   task automatic b_done(output logic [1:0] r);
      int n;
      n = 0;
      while (!bvalid && n < LIM) begin
         tick();
         n++;
      end
      r = bresp;
      bready = 1'b1;
      tick();
      bready = 1'b0;
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic [1:0] exp_r);
      logic [1:0] r;
      aw_w(a, d, s);
      b_done(r);
      check("bresp", 32'(r), 32'(exp_r));
   endtask

   // Optional push lands on the same edge as the AR handshake.
   task automatic rd(input logic [3:0] a, output logic [31:0] d,
                     input bit pw, input logic [15:0] pd);
      int n;
      araddr = a;
      arvalid = 1'b1;
      n = 0;
      while (!arready && n < LIM) begin
         tick();
         n++;
      end
      check("ar_ready", 32'(arready), 1);
      if (pw) begin
         res_valid = 1'b1;
         res_data  = pd;
      end
      tick();
      arvalid = 1'b0;
      res_valid = 1'b0;
      check("r_lat", 32'(rvalid), 1);
      d = rdata;
      rready = 1'b1;
      tick();
      rready = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [3:0] a,
                         input logic [31:0] exp);
      logic [31:0] d;
      rd(a, d, 1'b0, 16'h0);
      check(tag, d, exp);
   endtask

   task automatic push(input logic [15:0] d);
      res_valid = 1'b1;
      res_data  = d;
      tick();
      res_valid = 1'b0;
   endtask

   logic [31:0] d;

   initial begin
      rst = 1'b1;
      awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
      awvalid = 0; wvalid = 0; wdata = '0; wstrb = '0;
      bready = 0; arvalid = 0; rready = 0;
      res_valid = 0; res_data = '0;
      repeat (3) tick();
      check("rst_aw", 32'({awready, wready, arready}), 0);
      check("rst_v", 32'({bvalid, rvalid}), 0);
      check("rst_resp", 32'({bresp, rresp}), 0);
      check("rst_rdata", rdata, 0);
      check("rst_out", 32'({enable, irq}), 0);
      rst = 1'b0;
      tick();

      rd_chk("ctrl0", 4'h0, 32'h0);
      rd_chk("thr0", 4'h4, 32'h0);
      rd_chk("data_empty", 4'h8, 32'h0);
      rd_chk("stat_udf", 4'hC, 32'h0000_0009);
      wr(4'hC, 32'h8, 4'hF, 2'b00);
      rd_chk("stat_clr", 4'hC, 32'h0000_0001);

      wr(4'h0, 32'h1, 4'hF, 2'b00);
      check("enable", 32'(enable), 1);
      for (int i = 1; i <= 4; i++) push(16'(i));
      for (int i = 1; i <= 4; i++) rd_chk("fifo_ord", 4'h8, 32'(i));
      rd_chk("stat_drain", 4'hC, 32'h0000_0001);

      for (int i = 0; i < 9; i++) push(16'h10 + 16'(i));
      rd_chk("stat_full", 4'hC, 32'h0008_0006);
      rd_chk("full_head", 4'h8, 32'h10);
      push(16'h19);
      wr(4'hC, 32'h4, 4'hF, 2'b00);
      rd_chk("stat_full2", 4'hC, 32'h0008_0002);
      rd(4'h8, d, 1'b1, 16'h1A);
      check("pp_full_d", d, 32'h11);
      rd_chk("pp_full_st", 4'hC, 32'h0008_0002);
      wr(4'h0, 32'h5, 4'hF, 2'b00);
      rd_chk("flush_st", 4'hC, 32'h0000_0001);

      rd(4'h8, d, 1'b1, 16'h55);
      check("pp_empty_d", d, 32'h0);
      rd_chk("pp_empty_st", 4'hC, 32'h0001_0008);
      rd_chk("pp_empty_d2", 4'h8, 32'h55);
      wr(4'hC, 32'h8, 4'hF, 2'b00);

      wr(4'h4, 32'h3, 4'hF, 2'b00);
      wr(4'h0, 32'h7, 4'hF, 2'b00);
      rd_chk("ctrl_rd", 4'h0, 32'h3);
      push(16'hA1);
      push(16'hA2);
      push(16'hA3);
      check("irq_lag", 32'(irq), 0);
      tick();
      check("irq_hi", 32'(irq), 1);
      rd_chk("irq_pop", 4'h8, 32'hA1);
      tick();
      check("irq_lo", 32'(irq), 0);
      wr(4'h0, 32'h4, 4'hF, 2'b00);
      push(16'h77);
      rd_chk("dis_ign", 4'hC, 32'h0000_0001);

      aw_w(4'h4, 32'hFFFF_FFFF, 4'hF);
      awaddr = 4'h0; wdata = 32'h1; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bhold_v", 32'(bvalid), 1);
         check("bhold_r", 32'(bresp), 0);
         check("bhold_aw", 32'(awready), 0);
      end
      awvalid = 1'b0; wvalid = 1'b0;
      begin
         logic [1:0] r;
         b_done(r);
         check("bhold_resp", 32'(r), 0);
      end
      rd_chk("thr_mask", 4'h4, 32'h0000_01FF);
      wr(4'h4, 32'h0, 4'h2, 2'b00);
      rd_chk("thr_strb", 4'h4, 32'h0000_00FF);
      wr(4'h8, 32'h1234, 4'hF, 2'b10);
      rd_chk("data_wr_st", 4'hC, 32'h0000_0001);

      wr(4'h0, 32'h1, 4'hF, 2'b00);
      aw_w(4'h4, 32'h5, 4'hF);
      rst = 1'b1;
      tick();
      check("rst_mid_b", 32'(bvalid), 0);
      check("rst_mid_en", 32'(enable), 0);
      tick();
      rst = 1'b0;
      tick();
      rd_chk("thr_rst", 4'h4, 32'h0);

      wr(4'h0, 32'h1, 4'hF, 2'b00);
      push(16'h8000);
`ifdef RESULT_SLV_SIGN_EXT_EN
      rd_chk("ext", 4'h8, 32'hFFFF_8000);
`else
      rd_chk("ext", 4'h8, 32'h0000_8000);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
